// File: rtl/kpn_pkg.sv
// Shared constants and types for the KPN channel FIFO.
package kpn_pkg;

    localparam int unsigned DEF_BITS_NUMBER   = 16;
    localparam int unsigned DEF_FIFO_ELEMENTS = 5;
    localparam int unsigned COUNT_W           = DEF_FIFO_ELEMENTS + 1;

    typedef logic [DEF_BITS_NUMBER-1:0] token_t;

endpackage

// File: rtl/kpn_channel_fifo_if.sv
// Write/read handshake and status bundle between the KPN channel and its neighbours.
interface kpn_channel_fifo_if
    import kpn_pkg::*;
#(
    parameter int unsigned BITS_NUMBER   = DEF_BITS_NUMBER,
    parameter int unsigned FIFO_ELEMENTS = DEF_FIFO_ELEMENTS
);

    logic                     wr;
    logic [BITS_NUMBER-1:0]   input_1;
    logic                     rd;
    logic [BITS_NUMBER-1:0]   output_1;
    logic                     valid;
    logic                     full;
    logic                     empty;
    logic [FIFO_ELEMENTS:0]   count;
    logic                     overflow_err;
    logic                     underflow_err;

    // Upstream queue / downstream process side
    modport master (
        output wr, input_1, rd,
        input  output_1, valid, full, empty, count, overflow_err, underflow_err
    );

    // Channel side
    modport slave (
        input  wr, input_1, rd,
        output output_1, valid, full, empty, count, overflow_err, underflow_err
    );

endinterface

// File: rtl/kpn_fifo_mem.sv
// Dual-port register array: synchronous write, registered read (reset clears only the read register).
module kpn_fifo_mem #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    // Storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; a same-edge write to raddr_i is not seen (old data returned)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/kpn_channel_fifo.sv
// Buffered Kahn channel: circular buffer with occupancy count, sticky error flags
// and a one-cycle-latency rd/valid read handshake.
module kpn_channel_fifo
    import kpn_pkg::*;
#(
    parameter int unsigned BITS_NUMBER   = DEF_BITS_NUMBER,
    parameter int unsigned FIFO_ELEMENTS = DEF_FIFO_ELEMENTS
) (
    input logic               clk,
    input logic               reset,
    kpn_channel_fifo_if.slave bus
);

    localparam int unsigned CW = FIFO_ELEMENTS + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** FIFO_ELEMENTS);

    logic [FIFO_ELEMENTS-1:0] w_ptr_q, w_ptr_d;
    logic [FIFO_ELEMENTS-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic                     full, empty, rd_acc, wr_acc;

    // Status decoded from the registered count only
    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    // Accept decisions and next-state for pointers, count, flags
    always_comb begin
        rd_acc  = bus.rd && !empty;
        // A read in the same cycle frees the slot, so a full buffer still takes the write
        wr_acc  = bus.wr && (!full || rd_acc);
        w_ptr_d = wr_acc ? w_ptr_q + 1'b1 : w_ptr_q;
        r_ptr_d = rd_acc ? r_ptr_q + 1'b1 : r_ptr_q;
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        valid_d = rd_acc;
        ovf_d   = ovf_q || (bus.wr && full && !rd_acc);
        unf_d   = unf_q || (bus.rd && empty);
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    kpn_fifo_mem #(
        .WIDTH  (BITS_NUMBER),
        .ADDR_W (FIFO_ELEMENTS)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_acc),
        .waddr_i (w_ptr_q),
        .wdata_i (bus.input_1),
        .re_i    (rd_acc),
        .raddr_i (r_ptr_q),
        .rdata_o (bus.output_1)
    );

    assign bus.valid         = valid_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.count         = count_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_kpn_channel_fifo.sv
// Scoreboard bench for kpn_channel_fifo: stimulus pushes expected read tokens,
// a negedge monitor pops and compares whenever valid is seen.
module tb_kpn_channel_fifo;
    import kpn_pkg::*;

    logic clk = 1'b0;
    logic reset;

    kpn_channel_fifo_if bus ();

    kpn_channel_fifo u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    token_t sb[$];      // tokens expected on output_1, in order
    token_t model[$];   // tokens the bench believes are stored
    bit     exp_ovf, exp_unf, exp_valid;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(model.size()));
        chk({tag, ".full"}, 32'(bus.full), 32'(model.size() == 32));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(model.size() == 0));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(exp_valid));
        chk({tag, ".ovf"}, 32'(bus.overflow_err), 32'(exp_ovf));
        chk({tag, ".unf"}, 32'(bus.underflow_err), 32'(exp_unf));
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1
    task automatic step(input logic w, input token_t d, input logic r);
        bit ra, wa;
        bus.wr      = w;
        bus.input_1 = d;
        bus.rd      = r;
        ra = r && (model.size() > 0);
        wa = w && ((model.size() < 32) || ra);
        if (ra) sb.push_back(model.pop_front());
        if (wa) model.push_back(d);
        if (w && !wa) exp_ovf = 1'b1;
        if (r && model.size() == 0 && !ra && !wa) exp_unf = 1'b1;
        if (r && !ra) exp_unf = 1'b1;
        exp_valid = ra;
        @(posedge clk);
        #1;
        chk_status("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model.delete();
        sb.delete();
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest expected token
    always @(negedge clk) begin
        if (!reset && bus.valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got output_1=%h, no token expected", bus.output_1);
            end else begin
                token_t e;
                e = sb.pop_front();
                if (bus.output_1 !== e) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h (t=%0t)", bus.output_1, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.input_1 = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("por.count", 32'(bus.count), 0);
        chk("por.empty", 32'(bus.empty), 1);
        chk("por.full", 32'(bus.full), 0);
        chk("por.valid", 32'(bus.valid), 0);
        do_reset();

        // Latency and ordering
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        chk("order.count3", 32'(bus.count), 3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("order.empty", 32'(bus.empty), 1);
        chk("order.last", 32'(bus.output_1), 32'h0003);
        idle(1);

        // Asynchronous reset between edges with data in flight
        step(1'b1, 16'h00AA, 1'b0);
        step(1'b1, 16'h00BB, 1'b0);
        step(1'b0, '0, 1'b1);
        bus.rd = 1'b0;
        #5;
        reset = 1'b1;
        #1;
        chk("areset.count", 32'(bus.count), 0);
        chk("areset.full", 32'(bus.full), 0);
        chk("areset.empty", 32'(bus.empty), 1);
        chk("areset.valid", 32'(bus.valid), 0);
        chk("areset.out", 32'(bus.output_1), 0);
        chk("areset.ovf", 32'(bus.overflow_err), 0);
        chk("areset.unf", 32'(bus.underflow_err), 0);
        do_reset();

        // Fill, overflow, drain, wrap
        for (int i = 0; i < 32; i++) step(1'b1, token_t'(16'h0100 + i), 1'b0);
        chk("fill.full", 32'(bus.full), 1);
        chk("fill.count", 32'(bus.count), 32);
        step(1'b1, 16'hDEAD, 1'b0);
        chk("ovf.flag", 32'(bus.overflow_err), 1);
        chk("ovf.count", 32'(bus.count), 32);
        for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1);
        chk("drain.last", 32'(bus.output_1), 32'h011F);
        step(1'b1, 16'h0200, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("wrap.out", 32'(bus.output_1), 32'h0200);
        idle(1);

        // Simultaneous read/write while full
        for (int i = 0; i < 32; i++) step(1'b1, token_t'(16'h0300 + i), 1'b0);
        step(1'b1, 16'hBEEF, 1'b1);
        chk("simfull.out", 32'(bus.output_1), 32'h0300);
        chk("simfull.count", 32'(bus.count), 32);
        chk("simfull.ovf", 32'(bus.overflow_err), 1);
        for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1);
        chk("simfull.last", 32'(bus.output_1), 32'hBEEF);
        idle(1);

        // Simultaneous read/write while empty: no bypass
        do_reset();
        step(1'b1, 16'h0055, 1'b1);
        chk("simempty.valid", 32'(bus.valid), 0);
        chk("simempty.unf", 32'(bus.underflow_err), 1);
        step(1'b0, '0, 1'b1);
        chk("simempty.out", 32'(bus.output_1), 32'h0055);
        chk("simempty.valid2", 32'(bus.valid), 1);
        idle(1);

        // Upstream pairing: wr every other cycle, tokens 0..3 repeating, no reads
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step((i % 2) == 0, token_t'((i / 2) % 4), 1'b0);
            if (i % 2 == 1) chk("pair.count", 32'(bus.count), 32'((i + 1) / 2));
        end
        chk("pair.full", 32'(bus.full), 1);
        chk("pair.ovf", 32'(bus.overflow_err), 0);
        for (int i = 0; i < 32; i++) step(1'b0, '0, 1'b1);
        idle(2);

        chk("sb.drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kpn_channel_fifo.md
Name: kpn_channel_fifo

Overview:
- Buffered KPN channel that sits directly downstream of the precharged source queue.
- Captures each 16-bit token presented on the source's output_1 whenever its wr strobe is high.
- Stores tokens in a circular buffer and hands them to the next KPN process through an rd/valid read handshake.
- Provides the blocking-read and blocking-write semantics a Kahn channel needs: full and empty status, occupancy count, and sticky overflow/underflow error flags.

Parameters:
- BITS_NUMBER, 16: token width in bits.
- FIFO_ELEMENTS, 5: address width. Depth is 2**FIFO_ELEMENTS, so 32 entries by default.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write strobe from the upstream queue; one token per high cycle.
- input_1  input  BITS_NUMBER  token from the upstream queue, sampled when wr=1.
- rd  input  1  read request from the downstream process.
- output_1  output  BITS_NUMBER  token read out; registered.
- valid  output  1  high for exactly one cycle when output_1 carries a freshly read token.
- full  output  1  buffer holds 2**FIFO_ELEMENTS tokens.
- empty  output  1  buffer holds 0 tokens.
- count  output  FIFO_ELEMENTS+1  current occupancy, 0..2**FIFO_ELEMENTS.
- overflow_err  output  1  sticky; set on a dropped write.
- underflow_err  output  1  sticky; set on a read request while empty.

Behaviour:
- Reset (asynchronous, active-high):
  - w_ptr=0, r_ptr=0, count=0.
  - empty=1, full=0, valid=0, output_1=0.
  - overflow_err=0, underflow_err=0.
  - Array contents are not cleared.
  - A reset mid-operation discards all stored tokens immediately, without waiting for a clock edge.
- Write accept condition: wr=1 and (full=0 or read accept in the same cycle).
  - On accept: array[w_ptr] <= input_1, and w_ptr increments modulo 2**FIFO_ELEMENTS.
- Read accept condition: rd=1 and empty=0.
  - On accept: output_1 <= array[r_ptr] and valid <= 1 on the next edge (latency 1 cycle), and r_ptr increments modulo depth.
  - Otherwise valid <= 0 and output_1 holds its last value.
- Simultaneous read and write:
  - Not empty: both accepted and count unchanged.
  - Full: both accepted, the oldest token is read, and full stays 1.
  - Empty: only the write is accepted, with no bypass. The read is refused, underflow_err sets, and the token becomes readable from the next cycle.
- Count update: count = count + write_accept - read_accept.
  - full = (count == 2**FIFO_ELEMENTS); empty = (count == 0). Both are decoded from the registered count, with no combinational path from wr or rd.
- Pointer wrap: pointers are FIFO_ELEMENTS bits wide and wrap naturally from 31 to 0. Full and empty are distinguished by count, never by pointer compare.
- Overflow: wr=1 while full=1 and no read accept → token dropped, overflow_err <= 1.
- Underflow: rd=1 while empty=1 → underflow_err <= 1.
- Both error flags are sticky until reset.
- The upstream queue strobes wr every other cycle, so sustained throughput is 0.5 tokens/cycle inbound. The block nevertheless must accept back-to-back writes every cycle.

Decomposition:
- Shared package kpn_pkg:
  - BITS_NUMBER and FIFO_ELEMENTS defaults.
  - A token typedef of BITS_NUMBER bits.
  - The count width constant FIFO_ELEMENTS+1.
- One natural sub-module, kpn_fifo_mem: a simple dual-port register array with a synchronous write port and a registered read port.
- The pointer, count, flag and handshake logic stays in kpn_channel_fifo.

Test Plan:
- Reset state: assert reset mid-cycle with no clock edge → full=0, empty=1, count=0, valid=0, output_1=0x0000 immediately.
- Latency and ordering: write 0x0001, 0x0002, 0x0003 on consecutive cycles, then assert rd for 3 cycles → valid high on 3 consecutive cycles with output_1 = 0x0001, 0x0002, 0x0003, each one cycle after its rd; count goes 3→0 and empty=1 at the end.
- Fill, overflow and wrap: write 32 tokens 0x0100..0x011F → full=1, count=32. A 33rd write of 0xDEAD → dropped and overflow_err=1. Read all 32, then write 0x0200 at pointer position 0 after wrap and read it → output_1=0x0200.
- Simultaneous on full: with the buffer full, wr=1 with 0xBEEF and rd=1 in the same cycle → output_1=0x0100, count stays 32, overflow_err unchanged. The last token read out is 0xBEEF.
- Simultaneous on empty: with the buffer empty, wr=1 with 0x0055 and rd=1 → valid=0 and underflow_err=1. On the next cycle rd=1 → output_1=0x0055, valid=1.
- Upstream pairing: connect to the precharged queue model (wr toggling every other cycle, tokens 0x0000..0x0003 repeating) with rd tied low → count increments every 2 cycles, the stored sequence matches the upstream order, and the block reaches full at 32 without loss.
